ifmap_spad_ctrl: RTL

Upstream controller and sequencer for the PE's 16-entry ifmap scratchpad (registered read, 1-cycle latency; rd/wr/addr/data_in in, data_out out).

---
 rtl/ifmap_spad_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratchpad sequencer: loads one row over valid/ready, then replays it in 1-D sliding-window order.
// Optional IFMAP_SPAD_REUSE_EN adds cfg_reuse to replay the stored row without reloading.
module ifmap_spad_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [ADDR_W:0]   cfg_filt,
  input  logic [1:0]        cfg_stride,
`ifdef IFMAP_SPAD_REUSE_EN
  input  logic              cfg_reuse,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              spad_wr,
  output logic              spad_rd,
  output logic [ADDR_W-1:0] spad_addr,
  output logic [DATA_W-1:0] spad_wdata,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t          state;
  logic [ADDR_W:0] len_q, filt_q, wptr, base, tap;
  logic [1:0]      stride_q;
  logic            loaded;

  logic            reuse;
  logic [ADDR_W:0] eff_len;
  logic            cfg_bad;
  logic            issue;
  logic            tap_end;
  logic            win_end;
  logic [ADDR_W:0] rd_addr;
  logic [ADDR_W+1:0] next_end;

`ifdef IFMAP_SPAD_REUSE_EN
  assign reuse = cfg_reuse;
`else
  assign reuse = 1'b0;
`endif

  // A replay keeps the length of the row already sitting in the spad.
  assign eff_len = reuse ? len_q : cfg_len;
  assign cfg_bad = (eff_len == '0) || (eff_len > DEPTH_V) || (cfg_filt == '0) ||
                   (cfg_filt > eff_len) || (cfg_stride == 2'd0) || (reuse && !loaded);

  assign issue    = (state == READ) && (!out_valid || out_ready);
  assign tap_end  = (tap == filt_q - 1'b1);
  assign rd_addr  = base + tap;
  // One extra bit so base+stride+filt cannot overflow before the compare.
  assign next_end = (ADDR_W + 2)'(base) + (ADDR_W + 2)'(stride_q) + (ADDR_W + 2)'(filt_q);
  assign win_end  = next_end > (ADDR_W + 2)'(len_q);

  assign in_ready   = (state == LOAD);
  assign spad_wr    = in_ready && in_valid;
  assign spad_rd    = issue;
  assign spad_addr  = spad_wr ? wptr[ADDR_W-1:0] : (spad_rd ? rd_addr[ADDR_W-1:0] : '0);
  assign spad_wdata = spad_wr ? in_data : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      filt_q    <= '0;
      stride_q  <= '0;
      wptr      <= '0;
      base      <= '0;
      tap       <= '0;
      loaded    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err <= cfg_bad;
            if (cfg_bad) begin
              done <= 1'b1;
            end else begin
              len_q    <= eff_len;
              filt_q   <= cfg_filt;
              stride_q <= cfg_stride;
              wptr     <= '0;
              base     <= '0;
              tap      <= '0;
              state    <= reuse ? READ : LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (wptr == len_q - 1'b1) begin
              wptr   <= '0;
              loaded <= 1'b1;
              state  <= READ;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        READ: begin
          // Without an issue out_valid is held by a stalled MAC, so nothing changes.
          if (issue) begin
            out_valid <= 1'b1;
            out_last  <= tap_end;
            if (tap_end) begin
              tap <= '0;
              if (win_end) state <= DRAIN;
              else         base  <= base + (ADDR_W + 1)'(stride_q);
            end else begin
              tap <= tap + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
